// File: rtl/disp_pkg.sv
// disp_pkg: shared constants and types for the display arbiter slice.
//   - digit codes (blank, dash), source encodings, FSM state type
//   - frame geometry: six 5-bit digit fields packed LSB-first (digit1 = [4:0])
package disp_pkg;

    localparam int DIGITS  = 6;
    localparam int DIG_W   = 5;
    localparam int FRAME_W = DIGITS * DIG_W;

    localparam logic [DIG_W-1:0] CODE_BLANK = 5'b10000;
    localparam logic [DIG_W-1:0] CODE_DASH  = 5'b10001;

    localparam logic SRC_VAL = 1'b0;
    localparam logic SRC_MSG = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    typedef logic [FRAME_W-1:0] frame_t;

    localparam frame_t FRAME_DASH = {DIGITS{CODE_DASH}};

    // Bit offset of digit field k (k = 0 is digit1).
    function automatic int dig_off(input int k);
        return DIG_W * k;
    endfunction

endpackage

// File: rtl/disp_arbiter_if.sv
// disp_arbiter_if: requester/display bundle for disp_arbiter.
//   slave  : arbiter side (takes requests + frames, drives grants and display)
//   master : requester/display side
//   REQ_x/FRAME_x  request and its 30-bit frame, GNT_x one-cycle grant
//   BUSY/SRC       dwell flag and source of the held frame
//   OUT1..OUT6     held digit codes, SCAN_SEL/SCAN_CODE multiplexed scan
interface disp_arbiter_if;
    import disp_pkg::*;

    logic             REQ_VAL;
    frame_t           FRAME_VAL;
    logic             GNT_VAL;
    logic             REQ_MSG;
    frame_t           FRAME_MSG;
    logic             GNT_MSG;
    logic             BUSY;
    logic             SRC;
    logic [DIG_W-1:0] OUT1, OUT2, OUT3, OUT4, OUT5, OUT6;
    logic [DIGITS-1:0] SCAN_SEL;
    logic [DIG_W-1:0] SCAN_CODE;

    modport slave (
        input  REQ_VAL, FRAME_VAL, REQ_MSG, FRAME_MSG,
        output GNT_VAL, GNT_MSG, BUSY, SRC,
        output OUT1, OUT2, OUT3, OUT4, OUT5, OUT6, SCAN_SEL, SCAN_CODE
    );

    modport master (
        output REQ_VAL, FRAME_VAL, REQ_MSG, FRAME_MSG,
        input  GNT_VAL, GNT_MSG, BUSY, SRC,
        input  OUT1, OUT2, OUT3, OUT4, OUT5, OUT6, SCAN_SEL, SCAN_CODE
    );

endinterface

// File: rtl/disp_scan.sv
// disp_scan: multiplexed digit scanner.
//   CLK, RST   clock, synchronous active-high reset
//   frame      held frame (digit1 in [4:0])
//   scan_sel   registered one-hot active digit, bit0 = digit1
//   scan_code  code of the active digit (combinational from frame and index)
// Free-running: a new frame shows on the current digit immediately.
module disp_scan
    import disp_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic              CLK,
    input  logic              RST,
    input  frame_t            frame,
    output logic [DIGITS-1:0] scan_sel,
    output logic [DIG_W-1:0]  scan_code
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DW-1:0] div;
    logic [2:0]    idx;

    always_ff @(posedge CLK) begin
        if (RST) begin
            div      <= '0;
            idx      <= '0;
            scan_sel <= 6'b000001;
        end else if (div == DW'(SCAN_DIV - 1)) begin
            div      <= '0;
            idx      <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            // rotating the one-hot keeps it equal to one-hot(idx)
            scan_sel <= {scan_sel[DIGITS-2:0], scan_sel[DIGITS-1]};
        end else begin
            div <= div + DW'(1);
        end
    end

    always_comb begin
        scan_code = CODE_BLANK;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == 3'(k)) scan_code = frame[dig_off(k) +: DIG_W];
        end
    end

endmodule

// File: rtl/disp_arbiter.sv
// disp_arbiter: shares the six-digit display between the value path and the
// status-message path, one frame at a time, each held for HOLD_CYCLES.
//   CLK, RST  clock, synchronous active-high reset
//   bus       disp_arbiter_if.slave: REQ/FRAME/GNT per class, BUSY, SRC,
//             OUT1..OUT6, SCAN_SEL, SCAN_CODE
// Ties go to the class not served last; the first tie after reset goes to MSG.
module disp_arbiter
    import disp_pkg::*;
#(
    parameter int HOLD_CYCLES = 25000000,
    parameter int SCAN_DIV    = 50000
) (
    input  logic           CLK,
    input  logic           RST,
    disp_arbiter_if.slave  bus
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    frame_t        frame, frame_n;
    logic          src, src_n;
    logic          last, last_n;
    logic          gv, gv_n;
    logic          gm, gm_n;

    logic          rv, rm, decide, win_msg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            frame <= FRAME_DASH;
            src   <= SRC_VAL;
            last  <= SRC_VAL;
            gv    <= 1'b0;
            gm    <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            frame <= frame_n;
            src   <= src_n;
            last  <= last_n;
            gv    <= gv_n;
            gm    <= gm_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        frame_n = frame;
        src_n   = src;
        last_n  = last;
        gv_n    = 1'b0;
        gm_n    = 1'b0;

        // A class whose grant is currently showing still has its request up
        // for this cycle; with a one-cycle dwell that stale request would
        // otherwise be granted twice.
        rv      = bus.REQ_VAL & ~gv;
        rm      = bus.REQ_MSG & ~gm;
        decide  = (state == IDLE) || (cnt == '0);
        win_msg = rm & (~rv | (last == SRC_VAL));

        if (decide) begin
            if (rv | rm) begin
                state_n = HOLD;
                cnt_n   = CW'(HOLD_CYCLES - 1);
                frame_n = win_msg ? bus.FRAME_MSG : bus.FRAME_VAL;
                src_n   = win_msg;
                last_n  = win_msg;
                gv_n    = ~win_msg;
                gm_n    = win_msg;
            end else begin
                state_n = IDLE;
            end
        end else begin
            cnt_n = cnt - CW'(1);
        end
    end

    assign bus.GNT_VAL = gv;
    assign bus.GNT_MSG = gm;
    assign bus.BUSY    = (state == HOLD);
    assign bus.SRC     = src;
    assign bus.OUT1    = frame[dig_off(0) +: DIG_W];
    assign bus.OUT2    = frame[dig_off(1) +: DIG_W];
    assign bus.OUT3    = frame[dig_off(2) +: DIG_W];
    assign bus.OUT4    = frame[dig_off(3) +: DIG_W];
    assign bus.OUT5    = frame[dig_off(4) +: DIG_W];
    assign bus.OUT6    = frame[dig_off(5) +: DIG_W];

    disp_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
        .CLK       (CLK),
        .RST       (RST),
        .frame     (frame),
        .scan_sel  (bus.SCAN_SEL),
        .scan_code (bus.SCAN_CODE)
    );

endmodule

// File: tb/tb_disp_arbiter.sv
// tb_disp_arbiter: two instances (dwell 8 and dwell 1, scan divider 2)
// checked every cycle against a behavioural model, plus directed scenarios
// and a randomized requester phase.
module tb_disp_arbiter;
    import disp_pkg::*;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    localparam int SDIV = 2;

    logic [1:0]             rst;
    logic [1:0][1:0]        rq;      // [dut][class], class 0 = VAL, 1 = MSG
    logic [1:0][1:0][29:0]  fr;

    disp_arbiter_if if_a();
    disp_arbiter_if if_b();

    assign if_a.REQ_VAL   = rq[0][0];
    assign if_a.REQ_MSG   = rq[0][1];
    assign if_a.FRAME_VAL = fr[0][0];
    assign if_a.FRAME_MSG = fr[0][1];
    assign if_b.REQ_VAL   = rq[1][0];
    assign if_b.REQ_MSG   = rq[1][1];
    assign if_b.FRAME_VAL = fr[1][0];
    assign if_b.FRAME_MSG = fr[1][1];

    disp_arbiter #(.HOLD_CYCLES(8), .SCAN_DIV(SDIV)) u_a (.CLK(CLK), .RST(rst[0]), .bus(if_a));
    disp_arbiter #(.HOLD_CYCLES(1), .SCAN_DIV(SDIV)) u_b (.CLK(CLK), .RST(rst[1]), .bus(if_b));

    logic [1:0]       o_gv, o_gm, o_busy, o_src;
    logic [1:0][29:0] o_fr;
    logic [1:0][5:0]  o_sel;
    logic [1:0][4:0]  o_code;

    assign o_gv[0]   = if_a.GNT_VAL;   assign o_gv[1]   = if_b.GNT_VAL;
    assign o_gm[0]   = if_a.GNT_MSG;   assign o_gm[1]   = if_b.GNT_MSG;
    assign o_busy[0] = if_a.BUSY;      assign o_busy[1] = if_b.BUSY;
    assign o_src[0]  = if_a.SRC;       assign o_src[1]  = if_b.SRC;
    assign o_sel[0]  = if_a.SCAN_SEL;  assign o_sel[1]  = if_b.SCAN_SEL;
    assign o_code[0] = if_a.SCAN_CODE; assign o_code[1] = if_b.SCAN_CODE;
    assign o_fr[0] = {if_a.OUT6, if_a.OUT5, if_a.OUT4, if_a.OUT3, if_a.OUT2, if_a.OUT1};
    assign o_fr[1] = {if_b.OUT6, if_b.OUT5, if_b.OUT4, if_b.OUT3, if_b.OUT2, if_b.OUT1};

    // Behavioural model: "busy with rem cycles left in the dwell" per instance.
    int          hold_of[2] = '{8, 1};
    bit          mb[2];
    int          mrem[2];
    bit          mlast[2];
    logic [29:0] mfr[2];
    bit          msrc[2];
    bit          mg[2][2];
    int          mcyc[2];
    bit          saw[2][2];
    bit          allow;

    int checks, errors, cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_step(input int d);
        bit dec, rv, rm, w;
        if (rst[d]) begin
            mb[d] = 0; mrem[d] = 0; mlast[d] = 0; msrc[d] = 0;
            mfr[d] = {6{5'b10001}};
            mg[d][0] = 0; mg[d][1] = 0; mcyc[d] = 0;
        end else begin
            dec = !mb[d] || mrem[d] == 0;
            // the class whose grant is showing cannot win again this cycle
            rv = rq[d][0] && !mg[d][0];
            rm = rq[d][1] && !mg[d][1];
            mcyc[d]++;
            mg[d][0] = 0; mg[d][1] = 0;
            if (dec) begin
                if (rv || rm) begin
                    w = rm && (!rv || mlast[d] == 0);
                    mfr[d] = fr[d][w]; msrc[d] = w; mlast[d] = w;
                    mb[d] = 1; mrem[d] = hold_of[d] - 1; mg[d][w] = 1;
                end else begin
                    mb[d] = 0;
                end
            end else begin
                mrem[d]--;
            end
        end
    endtask

    task automatic check_dut(input int d);
        int idx;
        logic [5:0] es;
        idx = (mcyc[d] / SDIV) % 6;
        es = 6'b000001 << idx;
        chk($sformatf("d%0d_gnt_val", d), o_gv[d], mg[d][0]);
        chk($sformatf("d%0d_gnt_msg", d), o_gm[d], mg[d][1]);
        chk($sformatf("d%0d_busy", d), o_busy[d], mb[d]);
        chk($sformatf("d%0d_src", d), o_src[d], msrc[d]);
        chk($sformatf("d%0d_out", d), o_fr[d], mfr[d]);
        chk($sformatf("d%0d_scan_sel", d), o_sel[d], es);
        chk($sformatf("d%0d_scan_code", d), o_code[d], mfr[d][idx*5 +: 5]);
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step(0);
        model_step(1);
        @(negedge CLK);
        cyc++;
        check_dut(0);
        check_dut(1);
    endtask

    // Requester behaviour: drop on the edge after GNT was seen.
    // mode 0: no new requests, 1: re-raise while allowed, 2: random
    task automatic upd(input int d, input int mode);
        for (int c = 0; c < 2; c++) begin
            if (saw[d][c]) begin
                rq[d][c] = 0; saw[d][c] = 0;
            end else if (mg[d][c]) begin
                saw[d][c] = 1;
            end else if (!rq[d][c]) begin
                if (mode == 1 && allow) rq[d][c] = 1;
                else if (mode == 2 && $urandom_range(0, 3) == 0) begin
                    rq[d][c] = 1; fr[d][c] = 30'($urandom);
                end
            end else if (mode == 2 && $urandom_range(0, 19) == 0) begin
                rq[d][c] = 0;   // abandoned before being served
            end
        end
    endtask

    task automatic step(input int m0, input int m1);
        tick();
        upd(0, m0);
        upd(1, m1);
    endtask

    initial begin
        int n;
        bit found;
        bit order[$];
        int gcyc[$];

        checks = 0; errors = 0; cyc = 0; allow = 0;
        rq = '0; fr = '0; rst = 2'b11;

        // reset
        step(0, 0); step(0, 0);
        chk("rst_out", o_fr[0], {6{5'b10001}});
        chk("rst_sel", o_sel[0], 6'b000001);
        chk("rst_busy", o_busy[0], 0);
        chk("rst_gnt", {o_gv[0], o_gm[0]}, 0);
        rst = 2'b00;

        // single VAL request
        fr[0][0] = {6{5'h0A}}; rq[0][0] = 1;
        step(0, 0);
        chk("A_gnt_val", o_gv[0], 1);
        chk("A_out", o_fr[0], {6{5'h0A}});
        chk("A_src", o_src[0], 0);
        n = o_busy[0];
        for (int i = 0; i < 15; i++) begin step(0, 0); n += o_busy[0]; end
        chk("A_busy_len", n, 8);

        // simultaneous requests, re-raised after every grant
        fr[0][0] = 30'h1234567; fr[0][1] = 30'h2BCDEF0;
        rq[0] = 2'b11; allow = 1;
        for (int i = 0; i < 40; i++) begin
            step(1, 0);
            if (o_gv[0] || o_gm[0]) begin
                order.push_back(o_gm[0]);
                gcyc.push_back(cyc);
                if (order.size() >= 4) allow = 0;
            end
        end
        chk("B_ngrants_ge4", order.size() >= 4, 1);
        for (int k = 0; k < 4 && k < order.size(); k++)
            chk($sformatf("B_order%0d", k), order[k], (k % 2 == 0) ? 1 : 0);
        for (int k = 0; k < 3 && k + 1 < gcyc.size(); k++)
            chk($sformatf("B_spacing%0d", k), gcyc[k+1] - gcyc[k], 8);
        for (int i = 0; i < 20; i++) step(0, 0);

        // reset in the middle of a VAL hold with MSG pending
        fr[0][0] = 30'h0ABCDE1; rq[0][0] = 1;
        step(0, 0);
        chk("C_gnt_val", o_gv[0], 1);
        fr[0][1] = 30'h3FEDCBA; rq[0][1] = 1;
        step(0, 0); step(0, 0);
        rst[0] = 1;
        step(0, 0);
        chk("C_rst_out", o_fr[0], {6{5'b10001}});
        chk("C_rst_busy", o_busy[0], 0);
        chk("C_rst_gnt", {o_gv[0], o_gm[0]}, 0);
        rst[0] = 0;
        found = 0;
        for (int i = 0; i < 2 && !found; i++) begin
            step(0, 0);
            if (o_gm[0]) found = 1;
        end
        chk("C_gnt_msg_after_rst", found, 1);
        for (int i = 0; i < 12; i++) step(0, 0);

        // scan of digits 1..6
        fr[0][0] = {5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1}; rq[0][0] = 1;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            step(0, 0);
            if (o_sel[0] == 6'b100000) n++;
        end
        chk("D_digit6_dwell", n > 0, 1);

        // dwell of one cycle, request still up during the grant cycle
        fr[1][0] = 30'h1555555; rq[1][0] = 1;
        n = 0;
        for (int i = 0; i < 6; i++) begin step(0, 0); n += o_gv[1]; end
        chk("E_single_gnt", n, 1);

        // randomized requesters with occasional reset
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 99) == 0) ? 2'b11 : 2'b00;
            step(2, 2);
        end
        rst = 2'b00;
        step(0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
